vga_timing_frame_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 25 MHz vga_clk.
- Drives DrawX/DrawY/blank into every sprite and background mapper, and hs/vs to the VGA pins.
- Also produces a per-frame tick and a free-running sprite animation frame index. Mappers select among running-pose ROM sets (R1..R4) with this index, so pose changes happen only during vertical blanking.

---
 rtl/vga_timing_frame_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_frame_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_frame_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync/blank
// decodes, per-frame tick, frame counter and sprite animation pose index.
//
// Ports:
//   vga_clk     : pixel clock, all flops rising-edge
//   reset_n     : asynchronous active-low reset
//   anim_en     : 1 lets the animation divider/pose advance on frame ticks
//   DrawX/DrawY : current horizontal/vertical counts
//   hs/vs       : active-low syncs
//   blank       : 1 on visible pixels
//   frame_tick  : one-cycle pulse at (0, V_VISIBLE)
//   frame_count : completed-frame counter, wraps
//   anim_frame  : current pose index, 0..ANIM_FRAMES-1
module vga_timing_frame_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned ANIM_DIV    = 6,
  parameter int unsigned ANIM_FRAMES = 4
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        anim_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic [3:0]  anim_frame
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END =
    10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END =
    10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int unsigned DIV_W =
    (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
  localparam logic [3:0] ANIM_LAST = 4'(ANIM_FRAMES - 1);

  logic [9:0]       hc_q, hc_d;
  logic [9:0]       vc_q, vc_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_q, blank_d;
  logic             tick_q, tick_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       anim_q, anim_d;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  // Decode the upcoming position so flags line up with DrawX/DrawY.
  always_comb begin
    hs_d    = !((hc_d >= HS_BEG) && (hc_d < HS_END));
    vs_d    = !((vc_d >= VS_BEG) && (vc_d < VS_END));
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
    tick_d  = (hc_d == '0) && (vc_d == V_VIS);
  end

  // Frame and pose bookkeeping act at the end of the tick cycle, so
  // poses only change inside vertical blanking.
  always_comb begin
    fcnt_d = fcnt_q;
    div_d  = div_q;
    anim_d = anim_q;
    if (tick_q) begin
      fcnt_d = fcnt_q + 16'd1;
      if (anim_en) begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          anim_d = (anim_q == ANIM_LAST) ? '0 : anim_q + 4'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= H_LAST;
      vc_q    <= V_LAST;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
      div_q   <= '0;
      anim_q  <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
      div_q   <= div_d;
      anim_q  <= anim_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_tick  = tick_q;
  assign frame_count = fcnt_q;
  assign anim_frame  = anim_q;

endmodule

// File: tb/tb_vga_timing_frame_gen.sv
// Directed bench for vga_timing_frame_gen on a reduced raster so that
// many frames fit in a short run.
module tb_vga_timing_frame_gen;

  localparam int HV  = 20;
  localparam int HF  = 3;
  localparam int HSY = 5;
  localparam int HB  = 4;
  localparam int VV  = 12;
  localparam int VF  = 2;
  localparam int VSY = 2;
  localparam int VB  = 3;
  localparam int AD  = 6;
  localparam int AF  = 4;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int FR  = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        anim_en = 1'b0;
  logic [9:0]  DrawX, DrawY;
  logic        hs, vs, blank, frame_tick;
  logic [15:0] frame_count;
  logic [3:0]  anim_frame;

  always #20 clk = ~clk;

  vga_timing_frame_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .ANIM_DIV(AD), .ANIM_FRAMES(AF)
  ) dut (
    .vga_clk(clk),
    .reset_n(rst_n),
    .anim_en(anim_en),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .hs(hs),
    .vs(vs),
    .blank(blank),
    .frame_tick(frame_tick),
    .frame_count(frame_count),
    .anim_frame(anim_frame)
  );

  int nvec = 0;
  int nerr = 0;
  int ex, ey, efc, ediv, eanim;
  bit etick;
  int errs = 0;
  int hs_low_l10, vs_low, ticks, cyc, last_org, period;
  int tick_x, tick_y;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    ex = HT - 1; ey = VT - 1; etick = 0;
    efc = 0; ediv = 0; eanim = 0; ticks = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (etick) begin
        efc = (efc + 1) % 65536;
        if (anim_en) begin
          if (ediv == AD - 1) begin
            ediv  = 0;
            eanim = (eanim == AF - 1) ? 0 : eanim + 1;
          end else begin
            ediv++;
          end
        end
      end
      ex++;
      if (ex == HT) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end
      etick = (ex == 0) && (ey == VV);
      cyc++;
      #1;
      if (DrawX !== 10'(ex)) errs++;
      if (DrawY !== 10'(ey)) errs++;
      if (hs !== !(ex >= HV + HF && ex < HV + HF + HSY)) errs++;
      if (vs !== !(ey >= VV + VF && ey < VV + VF + VSY)) errs++;
      if (blank !== (ex < HV && ey < VV)) errs++;
      if (frame_tick !== etick) errs++;
      if (frame_count !== 16'(efc)) errs++;
      if (anim_frame !== 4'(eanim)) errs++;
      if (DrawY == 10 && hs === 1'b0) hs_low_l10++;
      if (vs === 1'b0) vs_low++;
      if (frame_tick === 1'b1) begin
        ticks++;
        tick_x = DrawX;
        tick_y = DrawY;
      end
      if (DrawX == 0 && DrawY == 0) begin
        period   = cyc - last_org;
        last_org = cyc;
      end
    end
  endtask

  task automatic run_to_tick(input int k);
    int budget;
    budget = 2 * FR * (k + 1);
    while (ticks < k && budget > 0) begin
      run(1);
      budget--;
    end
    if (ticks < k) chk("tick_timeout", ticks, k);
    run(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mdl_reset();
    anim_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", DrawX, HT - 1);
    chk("rst_y", DrawY, VT - 1);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_blank", blank, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_fcnt", frame_count, 0);
    chk("rst_anim", anim_frame, 0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; last_org = 0;
    run(1);
    chk("first_x", DrawX, 0);
    chk("first_y", DrawY, 0);
    chk("first_blank", blank, 1);
    hs_low_l10 = 0; vs_low = 0; tick_x = -1; tick_y = -1;

    run(FR);
    chk("frame_period1", period, FR);
    chk("hs_low_line10", hs_low_l10, HSY);
    chk("vs_low_clocks", vs_low, VSY * HT);
    chk("ticks_frame1", ticks, 1);
    chk("tick_x", tick_x, 0);
    chk("tick_y", tick_y, VV);
    run(FR);
    chk("frame_period2", period, FR);
    chk("fcnt_2frames", frame_count, 2);
    chk("raster_model", errs, 0);
    errs = 0;

    do_reset();
    anim_en = 1'b1;
    run_to_tick(5);
    chk("anim_t5", anim_frame, 0);
    run_to_tick(6);
    chk("anim_t6", anim_frame, 1);
    run_to_tick(12);
    chk("anim_t12", anim_frame, 2);
    run_to_tick(18);
    chk("anim_t18", anim_frame, 3);
    run_to_tick(24);
    chk("anim_t24", anim_frame, 0);
    run_to_tick(30);
    chk("anim_t30", anim_frame, 1);
    chk("fcnt_t30", frame_count, 30);
    chk("anim_model", errs, 0);
    errs = 0;

    do_reset();
    anim_en = 1'b1;
    run_to_tick(6);
    chk("hold_t6", anim_frame, 1);
    for (int k = 7; k <= 12; k++) begin
      anim_en = 1'b1;
      run(100);
      anim_en = 1'b0;
      run_to_tick(k);
    end
    chk("hold_t12", anim_frame, 1);
    chk("hold_fcnt12", frame_count, 12);
    anim_en = 1'b1;
    run_to_tick(17);
    chk("hold_t17", anim_frame, 1);
    run_to_tick(18);
    chk("hold_t18", anim_frame, 2);
    chk("hold_fcnt18", frame_count, 18);
    chk("hold_model", errs, 0);
    errs = 0;

    for (int i = 0; i < 2 * FR; i++) begin
      if (DrawX == 10 && DrawY == 5) break;
      run(1);
    end
    chk("mid_reach_y", DrawY, 5);
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("mid_rst_x", DrawX, HT - 1);
    chk("mid_rst_y", DrawY, VT - 1);
    chk("mid_rst_blank", blank, 0);
    chk("mid_rst_anim", anim_frame, 0);
    chk("mid_rst_fcnt", frame_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    chk("mid_first_x", DrawX, 0);
    chk("mid_first_y", DrawY, 0);
    chk("mid_first_blank", blank, 1);
    run(FR + 5);
    chk("post_rst_model", errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
